// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter.
//   SH_*  : shift-mode encodings carried on the 2-bit mode port.
//   state_t: control states of the shift engine (idle / shifting / done).
package shift_pkg;

    localparam logic [1:0] SH_SLL = 2'b00;   // logical left, zero fill
    localparam logic [1:0] SH_SRL = 2'b01;   // logical right, zero fill
    localparam logic [1:0] SH_SRA = 2'b10;   // arithmetic right, sign fill
    localparam logic [1:0] SH_ROL = 2'b11;   // rotate left

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/nbit_shift_step.sv
// Combinational single-step shifter: moves val_i by amt_i (0..STEP) bits in
// the given mode and reports the last bit that left the word (for ROL, the
// last bit that wrapped around).
//   val_i  : value to shift
//   amt_i  : number of bit positions, 0..STEP
//   mode_i : SLL / SRL / SRA / ROL
//   val_o  : shifted value
//   last_o : last bit shifted out (0 when amt_i is 0; caller ignores it then)
module nbit_shift_step
    import shift_pkg::*;
#(
    parameter int N    = 32,
    parameter int STEP = 1,
    parameter int SW   = $clog2(STEP + 1)
) (
    input  logic [N-1:0]  val_i,
    input  logic [SW-1:0] amt_i,
    input  logic [1:0]    mode_i,
    output logic [N-1:0]  val_o,
    output logic          last_o
);

    // One candidate result per possible amount; all shifts are by constants,
    // so each candidate is pure wiring and the amount only drives a mux.
    logic [N-1:0] cand_val  [STEP+1];
    logic         cand_last [STEP+1];

    assign cand_val[0]  = val_i;
    assign cand_last[0] = 1'b0;

    for (genvar gi = 1; gi <= STEP; gi++) begin : g_amt
        logic [N-1:0] sll_v;
        logic [N-1:0] srl_v;
        logic [N-1:0] sra_v;
        logic [N-1:0] rol_v;

        assign sll_v = val_i << gi;
        assign srl_v = val_i >> gi;
        // Sign fill built explicitly so no signed arithmetic is involved.
        assign sra_v = (val_i >> gi) | ({N{val_i[N-1]}} << (N - gi));
        assign rol_v = (val_i << gi) | (val_i >> (N - gi));

        assign cand_val[gi] = (mode_i == SH_SLL) ? sll_v :
                              (mode_i == SH_SRL) ? srl_v :
                              (mode_i == SH_SRA) ? sra_v : rol_v;

        // Left moves lose/wrap the upper bits, right moves lose the lower bits;
        // the last one to go is the one nearest the kept part of the word.
        assign cand_last[gi] = (mode_i == SH_SLL || mode_i == SH_ROL) ?
                               val_i[N - gi] : val_i[gi - 1];
    end

    assign val_o  = cand_val[amt_i];
    assign last_o = cand_last[amt_i];

endmodule

// File: rtl/seq_shift_reg.sv
// N-bit register with parallel load and a multi-cycle shift engine that moves
// at most STEP bits per clock. The pipeline stalls while busy is high.
//   clk      : clock, all state changes on the rising edge
//   reset    : synchronous, active-low; clears everything and aborts any op
//   load     : parallel load strobe (beats start, aborts an op in flight)
//   data     : parallel load value
//   start    : request a shift; accepted in IDLE or DONE, ignored while busy
//   mode     : 00 SLL, 01 SRL, 10 SRA, 11 ROL (sampled with start)
//   shamt    : shift amount 0..N-1 (sampled with start)
//   Q        : register contents
//   busy     : high while shifting
//   done     : one-cycle pulse, Q holds the final result
//   last_out : last bit shifted out (ROL: last bit wrapped)
module seq_shift_reg
    import shift_pkg::*;
#(
    parameter int N    = 32,
    parameter int SHW  = $clog2(N),
    parameter int STEP = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [N-1:0]   data,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [SHW-1:0] shamt,
    output logic [N-1:0]   Q,
    output logic           busy,
    output logic           done,
    output logic           last_out
);

    localparam int SW = $clog2(STEP + 1);

    state_t         state_q;
    logic [N-1:0]   q_q;
    logic           last_q;
    logic [SHW-1:0] cnt_q;      // bits still to shift
    logic [1:0]     mode_q;     // mode latched at start

    logic [SW-1:0]  step_d;     // bits moved on this edge: min(STEP, cnt)
    logic [SHW-1:0] cnt_d;      // remaining count after this edge
    logic [N-1:0]   q_shift_d;
    logic           last_shift_d;

    always_comb begin
        step_d = SW'(STEP);
        if (int'(cnt_q) < STEP) begin
            step_d = SW'(cnt_q);
        end
    end

    // step_d never exceeds cnt_q, so it always fits the count width here.
    assign cnt_d = cnt_q - SHW'(step_d);

    nbit_shift_step #(
        .N    (N),
        .STEP (STEP),
        .SW   (SW)
    ) u_step (
        .val_i  (q_q),
        .amt_i  (step_d),
        .mode_i (mode_q),
        .val_o  (q_shift_d),
        .last_o (last_shift_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= SH_SLL;
        end else if (load) begin
            // Load wins over everything but reset and silently drops any op.
            q_q     <= data;
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_q  <= mode;
                        cnt_q   <= shamt;
                        state_q <= (shamt == '0) ? ST_DONE : ST_SHIFT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    q_q    <= q_shift_d;
                    last_q <= last_shift_d;
                    cnt_q  <= cnt_d;
                    if (cnt_d == '0) begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Q        = q_q;
    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);
    assign last_out = last_q;

endmodule

// File: tb/tb_seq_shift_reg.sv
module tb_seq_shift_reg;
    import shift_pkg::*;

    localparam int N   = 32;
    localparam int SHW = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           load;
    logic [N-1:0]   data;
    logic           start;
    logic [1:0]     mode;
    logic [SHW-1:0] shamt;

    logic [N-1:0] q1, q4;
    logic         busy1, busy4, done1, done4, last1, last4;

    always #5 clk = ~clk;

    seq_shift_reg #(.N(N), .SHW(SHW), .STEP(1)) u_dut1 (
        .clk(clk), .reset(reset), .load(load), .data(data), .start(start),
        .mode(mode), .shamt(shamt), .Q(q1), .busy(busy1), .done(done1),
        .last_out(last1)
    );

    seq_shift_reg #(.N(N), .SHW(SHW), .STEP(4)) u_dut4 (
        .clk(clk), .reset(reset), .load(load), .data(data), .start(start),
        .mode(mode), .shamt(shamt), .Q(q4), .busy(busy4), .done(done4),
        .last_out(last4)
    );

    typedef struct {
        logic [N-1:0] q;
        logic         last;
        int           busy;
        string        name;
    } exp_t;

    exp_t sb1[$];
    exp_t sb4[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: register value and per-instance last bit out.
    logic [N-1:0] m_q;
    logic         m_last1, m_last4;

    // Whole shift by amt at once, straight from the mode definitions.
    function automatic void ref_shift(input logic [N-1:0] q, input logic [1:0] md,
                                      input int amt, input logic lin,
                                      output logic [N-1:0] qo, output logic lo);
        qo = q;
        lo = lin;
        if (amt == 0) return;
        case (md)
            SH_SLL: begin qo = q << amt; lo = q[N-amt]; end
            SH_SRL: begin qo = q >> amt; lo = q[amt-1]; end
            SH_SRA: begin qo = $signed(q) >>> amt; lo = q[amt-1]; end
            default: begin qo = (q << amt) | (q >> (N - amt)); lo = q[N-amt]; end
        endcase
    endfunction

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts busy cycles and pops one expectation per done pulse.
    int bc1 = 0, bc4 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            if (sb1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL s1_unexpected_done: got done=1 Q=0x%08h expected no done", q1);
            end else begin
                e = sb1.pop_front();
                check({e.name, "_s1_Q"}, q1, e.q);
                check({e.name, "_s1_last"}, N'(last1), N'(e.last));
                check({e.name, "_s1_busycycles"}, N'(bc1), N'(e.busy));
                $display("op %s step1: Q=0x%08h last=%0b busy=%0d", e.name, q1, last1, bc1);
            end
            bc1 = 0;
        end else if (busy1) bc1++;
        else bc1 = 0;

        if (done4) begin
            if (sb4.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL s4_unexpected_done: got done=1 Q=0x%08h expected no done", q4);
            end else begin
                e = sb4.pop_front();
                check({e.name, "_s4_Q"}, q4, e.q);
                check({e.name, "_s4_last"}, N'(last4), N'(e.last));
                check({e.name, "_s4_busycycles"}, N'(bc4), N'(e.busy));
                $display("op %s step4: Q=0x%08h last=%0b busy=%0d", e.name, q4, last4, bc4);
            end
            bc4 = 0;
        end else if (busy4) bc4++;
        else bc4 = 0;
    end

    task automatic wait_idle(input string nm);
        int t = 0;
        while ((busy1 || done1 || busy4 || done4) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got still busy after %0d cycles expected idle", nm, t);
        end
    endtask

    task automatic do_load(input logic [N-1:0] v, input string nm);
        @(negedge clk);
        load = 1'b1; data = v;
        @(negedge clk);
        load = 1'b0;
        check({nm, "_Q1"}, q1, v);
        check({nm, "_Q4"}, q4, v);
        check({nm, "_flags"}, N'({busy1, done1, busy4, done4}), '0);
        m_q = v;
        $display("load %s: 0x%08h", nm, v);
    endtask

    // Issue one op; poke=1 pulses a junk start/data during the busy phase.
    task automatic do_op(input logic [1:0] md, input int sh, input string nm, input bit poke);
        logic [N-1:0] nq;
        logic l1, l4;
        ref_shift(m_q, md, sh, m_last1, nq, l1);
        ref_shift(m_q, md, sh, m_last4, nq, l4);
        sb1.push_back('{nq, l1, sh, nm});
        sb4.push_back('{nq, l4, (sh + 3) / 4, nm});
        @(negedge clk);
        start = 1'b1; mode = md; shamt = sh[SHW-1:0];
        @(negedge clk);
        start = 1'b0;
        if (poke && sh > 0) begin
            start = 1'b1; mode = 2'($urandom); shamt = SHW'($urandom); data = $urandom;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle(nm);
        m_q = nq; m_last1 = l1; m_last4 = l4;
    endtask

    // Zero-length op followed by a second start accepted in the DONE cycle.
    task automatic do_b2b(input logic [1:0] md2, input int sh2);
        logic [N-1:0] nq;
        logic l1, l4;
        sb1.push_back('{m_q, m_last1, 0, "b2b_a"});
        sb4.push_back('{m_q, m_last4, 0, "b2b_a"});
        ref_shift(m_q, md2, sh2, m_last1, nq, l1);
        ref_shift(m_q, md2, sh2, m_last4, nq, l4);
        sb1.push_back('{nq, l1, sh2, "b2b_b"});
        sb4.push_back('{nq, l4, (sh2 + 3) / 4, "b2b_b"});
        @(negedge clk);
        start = 1'b1; mode = SH_SLL; shamt = '0;
        @(negedge clk);
        mode = md2; shamt = sh2[SHW-1:0];
        @(negedge clk);
        start = 1'b0;
        wait_idle("b2b");
        m_q = nq; m_last1 = l1; m_last4 = l4;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] tmp;
        logic         l1, l4;
        int           r;

        reset = 1'b0; load = 1'b0; start = 1'b0;
        data = '0; mode = SH_SLL; shamt = '0;
        m_q = '0; m_last1 = 1'b0; m_last4 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_Q1", q1, '0);
        check("reset_Q4", q4, '0);
        check("reset_flags", N'({busy1, done1, last1, busy4, done4, last4}), '0);
        reset = 1'b1;

        // Directed cases.
        do_load(32'h8000_0001, "t1");
        do_op(SH_SRA, 4, "t1_sra4", 1'b0);
        do_load(32'h8000_0001, "t2");
        do_op(SH_ROL, 1, "t2_rol1", 1'b0);
        do_op(2'($urandom), 0, "t3_zero", 1'b0);
        do_b2b(SH_SRL, 5);

        // Load during the third busy cycle aborts without a done.
        do_load(32'h1, "t4");
        @(negedge clk);
        start = 1'b1; mode = SH_SLL; shamt = 5'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        load = 1'b1; data = 32'hDEAD_BEEF;
        @(negedge clk);
        load = 1'b0;
        ref_shift(32'h1, SH_SLL, 2, m_last1, tmp, l1);
        ref_shift(32'h1, SH_SLL, 8, m_last4, tmp, l4);
        m_q = 32'hDEAD_BEEF; m_last1 = l1; m_last4 = l4;
        check("t4_abort_Q1", q1, m_q);
        check("t4_abort_Q4", q4, m_q);
        check("t4_abort_last", N'({last1, last4}), N'({l1, l4}));
        check("t4_abort_flags", N'({busy1, done1, busy4, done4}), '0);
        $display("abort t4: Q=0x%08h", q1);
        do_op(SH_SRL, 3, "t4_after", 1'b0);

        // Reset in the middle of a shift, with start held high.
        do_load($urandom, "t5");
        @(negedge clk);
        start = 1'b1; mode = SH_SRL; shamt = 5'd20;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0; start = 1'b1; shamt = 5'd7;
        repeat (2) @(negedge clk);
        check("t5_reset_Q1", q1, '0);
        check("t5_reset_Q4", q4, '0);
        check("t5_reset_flags", N'({busy1, done1, last1, busy4, done4, last4}), '0);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        check("t5_post_flags", N'({busy1, done1, busy4, done4}), '0);
        m_q = '0; m_last1 = 1'b0; m_last4 = 1'b0;
        $display("reset t5: Q=0x%08h", q1);

        do_load(32'hFFFF_FFFF, "t6");
        do_op(SH_SRL, 9, "t6_srl9", 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15) do_load($urandom, $sformatf("rl%0d", i));
            else if (r < 25) do_op(2'($urandom), 0, $sformatf("rz%0d", i), 1'b0);
            else do_op(2'($urandom), int'($urandom_range(1, N - 1)),
                       $sformatf("r%0d", i), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("pending_ops", N'(sb1.size() + sb4.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
